// File: rtl/prog_loader_if.sv
// Byte-stream handshake bundle feeding prog_loader.
//   in_data   stream byte
//   in_valid  in_data is valid
//   in_ready  loader can accept a byte
// Modports: master = byte source, slave = loader.
interface prog_loader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: receives a framed instruction image over a valid/ready byte
// stream, writes it into instruction memory through the program port and
// sequences the CPU reset around the load.
//
// Frame: header {MAGIC, N-1}, N instruction bytes, then (with the
// PROG_LOADER_CHECKSUM_EN macro defined) one XOR checksum byte.
//
// Ports:
//   clk          single clock, also clocks instruction memory writes
//   reset_n      asynchronous active-low reset
//   in_if        byte stream (slave side): in_data / in_valid / in_ready
//   prog_enable  steers the instruction memory address mux to prog_addr
//   prog_we      one-cycle instruction memory write strobe
//   prog_addr    write address (holds when prog_we = 0)
//   prog_data    write data (holds when prog_we = 0)
//   cpu_reset    active-high CPU reset
//   load_done    high while the CPU runs a loaded image
//   load_err     sticky checksum failure; constant 0 without the macro
//
// Build option: `define PROG_LOADER_CHECKSUM_EN adds the checksum byte and
// the CHK / ERR states.
module prog_loader #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 4,
    parameter logic [ADDR_WIDTH-1:0] MAGIC          = 'hA,
    parameter int                    RELEASE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    prog_loader_if.slave          in_if,
    output logic                  prog_enable,
    output logic                  prog_we,
    output logic [ADDR_WIDTH-1:0] prog_addr,
    output logic [DATA_WIDTH-1:0] prog_data,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_err
);

    localparam logic [3:0] REL_LAST = 4'(RELEASE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_HDR,
        ST_LOAD,
        ST_DRAIN,
        ST_RELEASE,
        ST_RUN
`ifdef PROG_LOADER_CHECKSUM_EN
        ,
        ST_CHK,
        ST_ERR
`endif
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] idx, idx_nxt;
    logic [ADDR_WIDTH-1:0] last_idx, last_idx_nxt;
    logic [3:0]            rel_cnt, rel_cnt_nxt;
    logic                  we_nxt, en_nxt, rst_nxt, done_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  ready_nxt;
    logic                  accept;
    logic                  hdr_hit;
    logic [ADDR_WIDTH-1:0] hdr_len;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum, csum_nxt;
    logic                  err_nxt;
`endif

    assign accept  = in_if.in_valid && in_if.in_ready;
    assign hdr_hit = (in_if.in_data[DATA_WIDTH-1 -: ADDR_WIDTH] == MAGIC);
    assign hdr_len = in_if.in_data[ADDR_WIDTH-1:0];

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        last_idx_nxt = last_idx;
        rel_cnt_nxt  = rel_cnt;
        we_nxt       = 1'b0;
        addr_nxt     = prog_addr;
        data_nxt     = prog_data;
        en_nxt       = prog_enable;
        rst_nxt      = cpu_reset;
        done_nxt     = load_done;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_nxt     = csum;
        err_nxt      = load_err;
`endif

        case (state)
            ST_HDR: begin
                if (accept && hdr_hit) begin
                    last_idx_nxt = hdr_len;
                    idx_nxt      = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_nxt     = '0;
`endif
                    state_nxt    = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (accept) begin
                    we_nxt   = 1'b1;
                    addr_nxt = idx;
                    data_nxt = in_if.in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_nxt = csum ^ in_if.in_data;
`endif
                    // Index saturates on the last byte so prog_addr ends at N-1.
                    if (idx == last_idx) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_nxt = ST_CHK;
`else
                        state_nxt = ST_DRAIN;
`endif
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end

`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    if (in_if.in_data == csum) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        err_nxt   = 1'b1;
                        en_nxt    = 1'b0;
                        state_nxt = ST_ERR;
                    end
                end
            end

            ST_ERR: begin
                if (accept && hdr_hit) begin
                    err_nxt      = 1'b0;
                    en_nxt       = 1'b1;
                    last_idx_nxt = hdr_len;
                    idx_nxt      = '0;
                    csum_nxt     = '0;
                    state_nxt    = ST_LOAD;
                end
            end
`endif

            // The final write strobe occupies this cycle; release the mux after it.
            ST_DRAIN: begin
                en_nxt      = 1'b0;
                rel_cnt_nxt = '0;
                state_nxt   = ST_RELEASE;
            end

            ST_RELEASE: begin
                if (rel_cnt == REL_LAST) begin
                    rst_nxt   = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    rel_cnt_nxt = rel_cnt + 1'b1;
                end
            end

            ST_RUN: begin
                if (accept && hdr_hit) begin
                    rst_nxt      = 1'b1;
                    en_nxt       = 1'b1;
                    done_nxt     = 1'b0;
                    last_idx_nxt = hdr_len;
                    idx_nxt      = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_nxt     = '0;
`endif
                    state_nxt    = ST_LOAD;
                end
            end

            default: state_nxt = ST_HDR;
        endcase

        // in_ready is registered from the next state, so it is a pure decode
        // of the state register and reads 0 throughout reset.
        ready_nxt = (state_nxt != ST_DRAIN) && (state_nxt != ST_RELEASE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_HDR;
            idx            <= '0;
            last_idx       <= '0;
            rel_cnt        <= '0;
            prog_we        <= 1'b0;
            prog_addr      <= '0;
            prog_data      <= '0;
            prog_enable    <= 1'b1;
            cpu_reset      <= 1'b1;
            load_done      <= 1'b0;
            in_if.in_ready <= 1'b0;
        end else begin
            state          <= state_nxt;
            idx            <= idx_nxt;
            last_idx       <= last_idx_nxt;
            rel_cnt        <= rel_cnt_nxt;
            prog_we        <= we_nxt;
            prog_addr      <= addr_nxt;
            prog_data      <= data_nxt;
            prog_enable    <= en_nxt;
            cpu_reset      <= rst_nxt;
            load_done      <= done_nxt;
            in_if.in_ready <= ready_nxt;
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum     <= '0;
            load_err <= 1'b0;
        end else begin
            csum     <= csum_nxt;
            load_err <= err_nxt;
        end
    end
`else
    assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames from the test plan plus
// randomized frames, junk bytes and handshake gaps, checked against an image
// model and the release timing rules.
module tb_prog_loader;
    localparam int R = 2;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    prog_loader_if #(.DATA_WIDTH(8)) sif ();

    logic       prog_enable, prog_we, cpu_reset, load_done, load_err;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;

    prog_loader #(
        .DATA_WIDTH    (8),
        .ADDR_WIDTH    (4),
        .MAGIC         (4'hA),
        .RELEASE_CYCLES(R)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_if      (sif),
        .prog_enable(prog_enable),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    // Downstream instruction memory driven by the program port.
    int         cyc      = 0;
    int         wr_count = 0;
    logic [7:0] tb_mem [16];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (prog_we === 1'b1) begin
            tb_mem[prog_addr] <= prog_data;
            wr_count          <= wr_count + 1;
        end
    end

    // Reference image: what memory should hold after every completed write.
    logic [7:0] image [16];
    bit         known [16];
    logic [7:0] frame [16];
    int         n_pass   = 0;
    int         n_checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic xfer(input logic [7:0] b);
        bit done;
        done = 1'b0;
        sif.in_data  = b;
        sif.in_valid = 1'b1;
        for (int t = 0; t < 40 && !done; t++) begin
            if (sif.in_ready === 1'b1) done = 1'b1;
            @(negedge clk);
        end
        chk("xfer_accepted", done, 1);
    endtask

    task automatic idle(input int k);
        sif.in_valid = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    function automatic logic [7:0] junk();
        logic [3:0] hi;
        hi = 4'($urandom_range(0, 14));
        if (hi >= 4'hA) hi = hi + 4'd1;
        return {hi, 4'($urandom)};
    endfunction

    task automatic check_mem();
        int bad;
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (known[i] && tb_mem[i] !== image[i]) bad++;
        chk("mem_image", bad, 0);
    endtask

    task automatic run_frame(input int n, input bit gappy, input bit reload);
        int w0;
`ifdef PROG_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
`endif
        w0 = wr_count;
        xfer({4'hA, 4'(n - 1)});
        if (reload) begin
            chk("reload_cpu_reset", cpu_reset, 1);
            chk("reload_done_low", load_done, 0);
            chk("reload_enable", prog_enable, 1);
`ifdef PROG_LOADER_CHECKSUM_EN
            chk("reload_err_clear", load_err, 0);
`endif
        end
        for (int i = 0; i < n; i++) begin
            if (gappy && $urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            xfer(frame[i]);
            chk("write_we", prog_we, 1);
            chk("write_addr", prog_addr, i);
            chk("write_data", prog_data, frame[i]);
            image[i] = frame[i];
            known[i] = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            x = x ^ frame[i];
`endif
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        if (gappy) idle(1);
        xfer(x);
`endif
        sif.in_valid = 1'b0;
        chk("enable_last_cycle", prog_enable, 1);
        @(negedge clk);
        chk("enable_fall", prog_enable, 0);
        chk("we_after_last", prog_we, 0);
        chk("reset_held", cpu_reset, 1);
        chk("ready_drain", sif.in_ready, 0);
        repeat (R - 1) @(negedge clk);
        chk("reset_still_held", cpu_reset, 1);
        chk("done_still_low", load_done, 0);
        @(negedge clk);
        chk("reset_released", cpu_reset, 0);
        chk("load_done", load_done, 1);
        chk("ready_run", sif.in_ready, 1);
        chk("write_count", wr_count - w0, n);
        check_mem();
    endtask

    initial begin
        int w0;
        int n;
        for (int i = 0; i < 16; i++) known[i] = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_data  = 8'h00;
        reset_n      = 1'b1;
        #2 reset_n   = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_ready", sif.in_ready, 0);
        chk("rst_enable", prog_enable, 1);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_we", prog_we, 0);
        chk("rst_addr", prog_addr, 0);
        chk("rst_data", prog_data, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_err, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", sif.in_ready, 1);

        // Non-magic byte in HDR is dropped.
        w0 = wr_count;
        xfer(8'h52);
        sif.in_valid = 1'b0;
        chk("hdr_junk_no_we", prog_we, 0);
        chk("hdr_junk_enable", prog_enable, 1);
        @(negedge clk);
        chk("hdr_junk_no_write", wr_count - w0, 0);
        frame[0] = 8'h7C;
        run_frame(1, 1'b0, 1'b0);

        // Junk in RUN leaves the CPU running.
        xfer(8'h33);
        sif.in_valid = 1'b0;
        chk("run_junk_no_we", prog_we, 0);
        chk("run_junk_cpu_runs", cpu_reset, 0);
        chk("run_junk_done", load_done, 1);

        frame[0] = 8'h11; frame[1] = 8'h22; frame[2] = 8'h33;
        run_frame(3, 1'b0, 1'b1);

        for (int i = 0; i < 16; i++) frame[i] = 8'(i);
        run_frame(16, 1'b0, 1'b1);
        chk("full_addr_end", prog_addr, 15);

`ifdef PROG_LOADER_CHECKSUM_EN
        frame[0] = 8'h0F; frame[1] = 8'hF0;
        run_frame(2, 1'b0, 1'b1);
        xfer(8'hA1);
        xfer(8'h0F);
        xfer(8'hF0);
        xfer(8'h00);
        sif.in_valid = 1'b0;
        image[0] = 8'h0F; image[1] = 8'hF0;
        @(negedge clk);
        chk("err_flag", load_err, 1);
        chk("err_cpu_reset", cpu_reset, 1);
        chk("err_enable", prog_enable, 0);
        chk("err_ready", sif.in_ready, 1);
        chk("err_done", load_done, 0);
        repeat (4) @(negedge clk);
        chk("err_sticky", load_err, 1);
        chk("err_cpu_held", cpu_reset, 1);
        xfer(junk());
        sif.in_valid = 1'b0;
        chk("err_junk_sticky", load_err, 1);
        for (int i = 0; i < 16; i++) frame[i] = 8'($urandom);
        run_frame($urandom_range(1, 16), 1'b1, 1'b1);
`endif

        repeat (6) begin
            if ($urandom_range(0, 1) == 1) begin
                xfer(junk());
                sif.in_valid = 1'b0;
                chk("rand_junk_no_we", prog_we, 0);
                chk("rand_junk_cpu_runs", cpu_reset, 0);
            end
            n = $urandom_range(1, 16);
            for (int i = 0; i < 16; i++) frame[i] = 8'($urandom);
            run_frame(n, 1'b1, 1'b1);
        end

        // Reset in the middle of a load.
        xfer(8'hA3);
        xfer(8'h01);
        xfer(8'h02);
        sif.in_valid = 1'b0;
        image[0] = 8'h01; image[1] = 8'h02;
        known[0] = 1'b1;  known[1] = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("async_ready", sif.in_ready, 0);
        chk("async_enable", prog_enable, 1);
        chk("async_cpu_reset", cpu_reset, 1);
        chk("async_we", prog_we, 0);
        chk("async_addr", prog_addr, 0);
        chk("async_data", prog_data, 0);
        chk("async_done", load_done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset2", sif.in_ready, 1);
        frame[0] = 8'h99;
        run_frame(1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader sitting directly upstream of the 4-bit CPU's instruction memory and address mux. It accepts a framed instruction image over a valid/ready byte interface, writes it into instruction memory through the memory's program port, and sequences the CPU reset. It replaces hand-driven `prog_enable`/`prog_we`/`cpu_reset` sequencing with a hardware FSM. The CPU is held in reset until an image has landed, then released after a fixed guard delay.

## Interface
- `DATA_WIDTH`, default 8: instruction / stream byte width; must equal 2*`ADDR_WIDTH`.
- `ADDR_WIDTH`, default 4: instruction memory address width; image holds up to 2^`ADDR_WIDTH` words.
- `MAGIC`, default 4'hA: header tag value in the upper `ADDR_WIDTH` bits of the header byte.
- `RELEASE_CYCLES`, default 2: cycles `cpu_reset` stays high after `prog_enable` falls; legal range 1..15.

Ports:
- `clk`  in  1  single clock; also clocks instruction memory writes.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  DATA_WIDTH  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader can accept a byte.
- `prog_enable`  out  1  steers the address mux to `prog_addr`.
- `prog_we`  out  1  one-cycle instruction memory write strobe.
- `prog_addr`  out  ADDR_WIDTH  write address.
- `prog_data`  out  DATA_WIDTH  write data (instruction).
- `cpu_reset`  out  1  active-high CPU reset.
- `load_done`  out  1  high while the CPU runs a loaded image.
- `load_err`  out  1  checksum failure (sticky); tied 0 without `PROG_LOADER_CHECKSUM_EN`.

## Operation
- Transfer occurs on a rising edge with `in_valid && in_ready`. Gaps in `in_valid` are legal anywhere.
- Frame layout: header `{MAGIC, N-1}`, then N instruction bytes, then (macro only) a checksum byte.
- States:
  - HDR: `in_ready`=1. A byte whose upper nibble ≠ `MAGIC` is consumed and discarded. A matching header latches N-1, clears the index, and goes to LOAD.
  - LOAD: `in_ready`=1. Each accepted byte produces a write of `prog_addr`=index, `prog_data`=byte.
    - Index increments per byte with no wrap; the N-th byte is the last.
    - After the last byte, go to CHK (macro) or DRAIN.
  - CHK: `in_ready`=1. The accepted byte is compared against the XOR of the N instruction bytes.
    - Match: go to DRAIN.
    - Mismatch: go to ERR.
  - DRAIN: `in_ready`=0. Waits for the final write cycle to finish. `prog_enable` drops the cycle after the last `prog_we` cycle, then go to RELEASE.
  - RELEASE: `in_ready`=0, `prog_enable`=0, `cpu_reset`=1. Counts `RELEASE_CYCLES`, then goes to RUN.
  - RUN: `cpu_reset`=0, `load_done`=1, `in_ready`=1.
    - Non-magic bytes are discarded.
    - A magic header triggers a reload: `cpu_reset`=1 and `prog_enable`=1 from the next cycle, `load_done`=0, go to LOAD.
  - ERR: `load_err`=1, `cpu_reset`=1, `prog_enable`=0, `in_ready`=1. A magic header clears `load_err` and goes to LOAD. Other bytes are discarded.
- `prog_addr` and `prog_data` hold their last value when `prog_we`=0.
- Reset values: `prog_enable`=1, `cpu_reset`=1, `prog_we`=0, `prog_addr`=0, `prog_data`=0, `load_done`=0, `load_err`=0, state=HDR. `in_ready`=0 while `reset_n` is low and 1 from the first cycle after release.
- `reset_n` asserted mid-LOAD: all outputs return to reset values immediately. Memory contents already written are not cleared. The next frame restarts at address 0.

## Timing
- Write latency: byte accepted at edge k drives `prog_we`=1 with addr/data stable during cycle k..k+1. Memory captures at edge k+1.
- Back-to-back bytes produce back-to-back `prog_we` cycles; throughput is one instruction per clock.
- Release sequence after the last write cycle:
  - 1 cycle later `prog_enable`=0.
  - `RELEASE_CYCLES` cycles later `cpu_reset`=0 and `load_done`=1.
- Reload latency: `cpu_reset` rises the cycle after the RUN-state header is accepted.
- All outputs are registered; `in_ready` decodes from the state register only.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined: CHK and ERR states exist. The frame carries a trailing XOR checksum byte. A mismatch keeps the CPU in reset with `load_err`=1.
- Undefined: no checksum byte is expected. LOAD goes directly to DRAIN. `load_err` is constant 0 and ERR is unreachable.

## Test plan
- Reset, stream A2,11,22,33 continuously -> three `prog_we` pulses at addr 0,1,2 with data 11,22,33; `prog_enable` falls 1 cycle after the last write; `cpu_reset` falls 2 cycles later; `load_done`=1.
- In HDR send 52, then A0,7C -> 52 discarded with no write; addr 0 written 7C; normal release.
- AF plus 16 bytes 00..0F with `in_valid` held high -> 16 consecutive write cycles at addr 0..15, no 17th write, `prog_addr` ends at 15.
- In RUN send 33 then A0,5D -> 33 ignored with the CPU still running; `cpu_reset` rises the cycle after A0 is accepted; addr 0 written 5D; re-release.
- Macro on: A1,0F,F0,FF -> release. Then A1,0F,F0,00 -> `load_err`=1, `cpu_reset` stays 1, `prog_enable`=0. A following header clears `load_err`.
- Drop `reset_n` after the second byte of A3,… -> outputs reset asynchronously. A subsequent A0,99 writes addr 0.
